// File: rtl/param_dcache_pkg.sv
// param_dcache_pkg: shared state encoding and default geometry for the data cache.
package param_dcache_pkg;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_NUM_LINES = 4;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_MEM_LATENCY = 4;
  typedef enum logic [2:0] {IDLE, WB, FILL, RESPOND, GRANT} cacheState;
endpackage

// File: rtl/param_dcache_if.sv
// param_dcache_if: datapath, memory, DMA arbitration and statistics signals of the cache.
interface param_dcache_if
  import param_dcache_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LINE_WORDS = DEF_LINE_WORDS
);
  logic readC, writeC, ready, hit;
  logic [WORD_SIZE-1:0] addressC, dataC_in, dataC_out;
  logic readM, writeM;
  logic [WORD_SIZE-1:0] addressM;
  logic [WORD_SIZE*LINE_WORDS-1:0] dataM_in, dataM_out;
  logic BR, BG;
  logic [WORD_SIZE-1:0] access_cnt, hit_cnt;
  modport slave (
    input readC, writeC, addressC, dataC_in, dataM_in, BR,
    output dataC_out, ready, hit, readM, writeM, addressM, dataM_out, BG, access_cnt, hit_cnt
  );
  modport master (
    output readC, writeC, addressC, dataC_in, dataM_in, BR,
    input dataC_out, ready, hit, readM, writeM, addressM, dataM_out, BG, access_cnt, hit_cnt
  );
endinterface

// File: rtl/param_dcache_line_store.sv
// dcache_line_store: tag/valid/dirty/data arrays with one combinational read port and one write port.
module dcache_line_store #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W = 12,
  parameter int LINE_W = 64,
  parameter int IDX_W = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rdIndex,
  output logic [TAG_W-1:0]  rdTag,
  output logic              rdValid,
  output logic              rdDirty,
  output logic [LINE_W-1:0] rdLine,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIndex,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic              wrValid,
  input  logic              wrDirty,
  input  logic [LINE_W-1:0] wrLine
);
  logic [TAG_W-1:0] tagMem [NUM_LINES];
  logic [LINE_W-1:0] dataMem [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wrEn) begin
      valid[wrIndex] <= wrValid;
      dirty[wrIndex] <= wrDirty;
    end
  // Tag and data contents are meaningless while valid is clear, so they need no reset.
  always_ff @(posedge clk)
    if (wrEn) begin
      tagMem[wrIndex] <= wrTag;
      dataMem[wrIndex] <= wrLine;
    end
  assign rdTag = tagMem[rdIndex];
  assign rdValid = valid[rdIndex];
  assign rdDirty = dirty[rdIndex];
  assign rdLine = dataMem[rdIndex];
endmodule

// File: rtl/param_dcache.sv
// param_dcache: direct-mapped write-back data cache with line fill/writeback, DMA bus grant and hit statistics.
module param_dcache
  import param_dcache_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic clk,
  input logic reset_n,
  param_dcache_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;
  localparam int PH_W = $clog2(MEM_LATENCY + 1);
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(MEM_LATENCY);
  cacheState state, nextState;
  logic [PH_W-1:0] phase;
  logic [WORD_SIZE-1:0] accessCnt, hitCnt, addrM, word;
  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag, rdTag;
  logic [LINE_W-1:0] rdLine, wrLine, mergedLine, lineOut;
  logic rdValid, rdDirty, wrEn, wrDirty, req, tagHit, lastPhase;
  logic ready, readM, writeM, grant;
  assign offset = bus.addressC[OFF_W-1:0];
  assign index = bus.addressC[OFF_W +: IDX_W];
  assign tag = bus.addressC[WORD_SIZE-1 -: TAG_W];
  assign req = bus.readC | bus.writeC;
  assign tagHit = rdValid && rdTag == tag;
  assign lastPhase = phase == PH_W'(1);
  assign word = rdLine[offset*WORD_SIZE +: WORD_SIZE];
  dcache_line_store #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .LINE_W(LINE_W)) store (
    .clk(clk), .reset_n(reset_n),
    .rdIndex(index), .rdTag(rdTag), .rdValid(rdValid), .rdDirty(rdDirty), .rdLine(rdLine),
    .wrEn(wrEn), .wrIndex(index), .wrTag(tag), .wrValid(1'b1), .wrDirty(wrDirty), .wrLine(wrLine)
  );
  always_comb begin
    mergedLine = rdLine;
    mergedLine[offset*WORD_SIZE +: WORD_SIZE] = bus.dataC_in;
  end
  always_comb begin
    nextState = state;
    ready = 1'b0;
    readM = 1'b0;
    writeM = 1'b0;
    grant = 1'b0;
    addrM = '0;
    lineOut = '0;
    wrEn = 1'b0;
    wrDirty = 1'b1;
    wrLine = mergedLine;
    case (state)
      IDLE: begin
        ready = req && tagHit;
        wrEn = bus.writeC && tagHit;
        nextState = bus.BR ? GRANT : (req && !tagHit) ? (rdValid && rdDirty ? WB : FILL) : IDLE;
      end
      WB: begin
        writeM = 1'b1;
        addrM = {rdTag, index, OFF_W'(0)};
        lineOut = rdLine;
        nextState = lastPhase ? FILL : WB;
      end
      // The line is installed only on the final fill edge, so an abandoned fill leaves nothing behind.
      FILL: begin
        readM = 1'b1;
        addrM = {bus.addressC[WORD_SIZE-1:OFF_W], OFF_W'(0)};
        wrEn = lastPhase;
        wrDirty = 1'b0;
        wrLine = bus.dataM_in;
        nextState = lastPhase ? RESPOND : FILL;
      end
      RESPOND: begin
        ready = 1'b1;
        wrEn = bus.writeC;
        nextState = IDLE;
      end
      GRANT: begin
        grant = 1'b1;
        nextState = bus.BR ? GRANT : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      phase <= '0;
      accessCnt <= '0;
      hitCnt <= '0;
    end else begin
      state <= nextState;
      phase <= state != nextState ? PH_LOAD : phase - PH_W'(1);
      accessCnt <= accessCnt + WORD_SIZE'(ready);
      hitCnt <= hitCnt + WORD_SIZE'(ready && state == IDLE);
    end
  assign bus.ready = ready;
  assign bus.hit = !reset_n || !req || (state == IDLE && tagHit);
  assign bus.dataC_out = ready && bus.readC ? word : '0;
  assign bus.readM = readM;
  assign bus.writeM = writeM;
  assign bus.addressM = addrM;
  assign bus.dataM_out = lineOut;
  assign bus.BG = grant;
  assign bus.access_cnt = accessCnt;
  assign bus.hit_cnt = hitCnt;
endmodule

// File: tb/tb_param_dcache.sv
// tb_param_dcache: directed checks of miss fill, hits, writeback, DMA grant, reset abort and a small geometry.
module tb_param_dcache;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  param_dcache_if #(.WORD_SIZE(16), .LINE_WORDS(4)) bus();
  param_dcache_if #(.WORD_SIZE(16), .LINE_WORDS(2)) sbus();
  param_dcache #(.WORD_SIZE(16), .NUM_LINES(4), .LINE_WORDS(4), .MEM_LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  param_dcache #(.WORD_SIZE(16), .NUM_LINES(8), .LINE_WORDS(2), .MEM_LATENCY(1)) dutSmall (
    .clk(clk), .reset_n(reset_n), .bus(sbus));
  // Memory word at address a holds a ^ 0x5A00.
  assign bus.dataM_in = {bus.addressM + 16'd3, bus.addressM + 16'd2, bus.addressM + 16'd1, bus.addressM} ^ {4{16'h5A00}};
  assign sbus.dataM_in = {sbus.addressM + 16'd1, sbus.addressM} ^ {2{16'h5A00}};
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic r, logic w, logic [15:0] a, logic [15:0] d);
    bus.readC = r;
    bus.writeC = w;
    bus.addressC = a;
    bus.dataC_in = d;
  endtask
  initial begin
    drive(0, 0, 16'h0, 16'h0);
    bus.BR = 0;
    sbus.readC = 0;
    sbus.writeC = 0;
    sbus.addressC = 0;
    sbus.dataC_in = 0;
    sbus.BR = 0;
    #12;
    check("rst ready", bus.ready, 0);
    check("rst hit", bus.hit, 1);
    check("rst readM", bus.readM, 0);
    check("rst writeM", bus.writeM, 0);
    check("rst BG", bus.BG, 0);
    check("rst addressM", bus.addressM, 0);
    check("rst dataM_out", bus.dataM_out, 0);
    check("rst dataC_out", bus.dataC_out, 0);
    check("rst access_cnt", bus.access_cnt, 0);
    check("rst hit_cnt", bus.hit_cnt, 0);
    @(negedge clk) reset_n = 1;
    cyc;
    drive(1, 0, 16'h0012, 0);
    @(negedge clk);
    check("miss0 ready", bus.ready, 0);
    check("miss0 hit", bus.hit, 0);
    check("miss0 readM", bus.readM, 0);
    cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill0 readM", bus.readM, 1);
      check("fill0 addressM", bus.addressM, 16'h0010);
      cyc;
    end
    @(negedge clk);
    check("resp0 ready", bus.ready, 1);
    check("resp0 data", bus.dataC_out, 16'h5A12);
    check("resp0 readM", bus.readM, 0);
    cyc;
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("cnt0 access", bus.access_cnt, 1);
    check("cnt0 hit", bus.hit_cnt, 0);
    check("idle hit", bus.hit, 1);
    cyc;
    drive(1, 0, 16'h0013, 0);
    @(negedge clk);
    check("hit1 ready", bus.ready, 1);
    check("hit1 hit", bus.hit, 1);
    check("hit1 data", bus.dataC_out, 16'h5A13);
    cyc;
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("cnt1 access", bus.access_cnt, 2);
    check("cnt1 hit", bus.hit_cnt, 1);
    cyc;
    drive(0, 1, 16'h0012, 16'hBEEF);
    @(negedge clk);
    check("wr ready", bus.ready, 1);
    check("wr hit", bus.hit, 1);
    check("wr dataC_out", bus.dataC_out, 0);
    cyc;
    drive(1, 0, 16'h0052, 0);
    @(negedge clk);
    check("miss2 ready", bus.ready, 0);
    check("miss2 writeM", bus.writeM, 0);
    cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wb writeM", bus.writeM, 1);
      check("wb readM", bus.readM, 0);
      check("wb addressM", bus.addressM, 16'h0010);
      check("wb word2", bus.dataM_out[47:32], 16'hBEEF);
      check("wb word0", bus.dataM_out[15:0], 16'h5A10);
      cyc;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill2 readM", bus.readM, 1);
      check("fill2 writeM", bus.writeM, 0);
      check("fill2 addressM", bus.addressM, 16'h0050);
      cyc;
    end
    @(negedge clk);
    check("resp2 ready", bus.ready, 1);
    check("resp2 data", bus.dataC_out, 16'h5A52);
    cyc;
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("cnt2 access", bus.access_cnt, 4);
    check("cnt2 hit", bus.hit_cnt, 2);
    cyc;
    bus.BR = 1;
    @(negedge clk);
    check("br0 BG", bus.BG, 0);
    cyc;
    @(negedge clk);
    check("grant BG", bus.BG, 1);
    cyc;
    drive(1, 0, 16'h0092, 0);
    @(negedge clk);
    check("grant ready", bus.ready, 0);
    check("grant hit", bus.hit, 0);
    check("grant readM", bus.readM, 0);
    check("grant addressM", bus.addressM, 0);
    cyc;
    @(negedge clk);
    check("grant hold ready", bus.ready, 0);
    check("grant hold BG", bus.BG, 1);
    cyc;
    bus.BR = 0;
    @(negedge clk);
    check("grant last BG", bus.BG, 1);
    cyc;
    @(negedge clk);
    check("post grant BG", bus.BG, 0);
    check("post grant readM", bus.readM, 0);
    check("post grant ready", bus.ready, 0);
    cyc;
    @(negedge clk);
    check("fill3 c1 readM", bus.readM, 1);
    check("fill3 addressM", bus.addressM, 16'h0090);
    cyc;
    @(negedge clk);
    check("fill3 c2 readM", bus.readM, 1);
    #1 reset_n = 0;
    #1;
    check("abort readM", bus.readM, 0);
    check("abort addressM", bus.addressM, 0);
    check("abort hit", bus.hit, 1);
    check("abort ready", bus.ready, 0);
    check("abort access", bus.access_cnt, 0);
    @(negedge clk) reset_n = 1;
    #1;
    check("rerd hit", bus.hit, 0);
    check("rerd ready", bus.ready, 0);
    cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill4 readM", bus.readM, 1);
      check("fill4 addressM", bus.addressM, 16'h0090);
      cyc;
    end
    @(negedge clk);
    check("resp4 ready", bus.ready, 1);
    check("resp4 data", bus.dataC_out, 16'h5A92);
    cyc;
    drive(1, 0, 16'h0093, 0);
    bus.BR = 1;
    @(negedge clk);
    check("brhit ready", bus.ready, 1);
    check("brhit hit", bus.hit, 1);
    check("brhit data", bus.dataC_out, 16'h5A93);
    cyc;
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("brhit BG", bus.BG, 1);
    check("cnt4 access", bus.access_cnt, 2);
    check("cnt4 hit", bus.hit_cnt, 1);
    cyc;
    bus.BR = 0;
    @(negedge clk);
    check("brhit BG hold", bus.BG, 1);
    cyc;
    @(negedge clk);
    check("brhit BG drop", bus.BG, 0);
    cyc;
    sbus.readC = 1;
    sbus.addressC = 16'h000E;
    @(negedge clk);
    check("small miss ready", sbus.ready, 0);
    cyc;
    @(negedge clk);
    check("small readM", sbus.readM, 1);
    check("small addressM", sbus.addressM, 16'h000E);
    cyc;
    @(negedge clk);
    check("small ready", sbus.ready, 1);
    check("small data", sbus.dataC_out, 16'h5A0E);
    check("small readM off", sbus.readM, 0);
    cyc;
    sbus.readC = 0;
    @(negedge clk);
    check("small access", sbus.access_cnt, 1);
    check("small hit_cnt", sbus.hit_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
